// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared types and constants for the RISC-V fetch pipeline: datapath width,
// branch-history index width, reset PC, bubble instruction, two-bit counter
// encodings, the IF/ID pipeline-register payload and the counter update rule.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

  localparam int unsigned WIDTH_DATA_LENGTH = 32;
  localparam int unsigned WIDTH_ENTRY_LENTH = 3;
  localparam int unsigned BHT_DEPTH         = 1 << WIDTH_ENTRY_LENTH;

  typedef logic [WIDTH_DATA_LENGTH-1:0] word_t;
  typedef logic [WIDTH_ENTRY_LENTH-1:0] bht_idx_t;

  localparam word_t RESET_PC  = WIDTH_DATA_LENGTH'(32'h0000_0000);
  localparam word_t NOP_INSTR = WIDTH_DATA_LENGTH'(32'h0000_0013);

  // Two-bit saturating branch-history counter states
  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } bht_cnt_e;

  // IF/ID pipeline-register payload
  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  pred_taken;
    word_t pred_target;
    logic  valid;
  } if_id_t;

  // Contents of IF/ID after reset or a flush
  localparam if_id_t IF_ID_BUBBLE = '{
    instr:       NOP_INSTR,
    pc:          '0,
    pred_taken:  1'b0,
    pred_target: '0,
    valid:       1'b0
  };

  // Saturating counter step toward taken / not-taken
  function automatic bht_cnt_e cnt_next(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CNT_ST) nxt = bht_cnt_e'(2'(cur + 2'd1));
    end else begin
      if (cur != CNT_SNT) nxt = bht_cnt_e'(2'(cur - 2'd1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage_if
// Signal bundle between the fetch stage and its neighbours (BTB, instruction
// memory, hazard unit, execute stage, decode).
//   master : the fetch stage; drives PC and the IF/ID register outputs
//   slave  : the surrounding pipeline; drives control, BTB, memory and
//            branch-resolution inputs
// Signals:
//   Stall, Mispredict, Redirect_PC        hazard / EX redirect control
//   Hit, Target_Add                       BTB lookup result for PC
//   Instr_In                              instruction memory read data for PC
//   Br_Resolved, Br_Taken, PC_Ex          EX branch resolution (history update)
//   PC                                    current fetch PC
//   IF_ID_Instr, IF_ID_PC, IF_ID_Pred_Taken,
//   IF_ID_Pred_Target, IF_ID_Valid        IF/ID pipeline register
// -----------------------------------------------------------------------------
interface pc_fetch_stage_if;
  import riscv_pipe_pkg::*;

  logic  Stall;
  logic  Mispredict;
  word_t Redirect_PC;
  logic  Hit;
  word_t Target_Add;
  word_t Instr_In;
  logic  Br_Resolved;
  logic  Br_Taken;
  word_t PC_Ex;

  word_t PC;
  word_t IF_ID_Instr;
  word_t IF_ID_PC;
  logic  IF_ID_Pred_Taken;
  word_t IF_ID_Pred_Target;
  logic  IF_ID_Valid;

  modport master (
    input  Stall, Mispredict, Redirect_PC, Hit, Target_Add, Instr_In,
           Br_Resolved, Br_Taken, PC_Ex,
    output PC, IF_ID_Instr, IF_ID_PC, IF_ID_Pred_Taken, IF_ID_Pred_Target,
           IF_ID_Valid
  );

  modport slave (
    output Stall, Mispredict, Redirect_PC, Hit, Target_Add, Instr_In,
           Br_Resolved, Br_Taken, PC_Ex,
    input  PC, IF_ID_Instr, IF_ID_PC, IF_ID_Pred_Taken, IF_ID_Pred_Target,
           IF_ID_Valid
  );

endinterface

// File: rtl/branch_history_table.sv
// -----------------------------------------------------------------------------
// branch_history_table
// 2^WIDTH_ENTRY_LENTH two-bit saturating counters indexed by
// PC[WIDTH_ENTRY_LENTH+1:2]. Combinational read on the fetch PC, one update
// per cycle at the resolved branch PC. A read of the entry being updated in
// the same cycle returns the pre-update value.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (counters -> WNT)
//   rd_pc_i        fetch PC to look up
//   rd_taken_c     MSB of the looked-up counter (combinational)
//   upd_en_i       a conditional branch resolved this cycle
//   upd_taken_i    its outcome
//   upd_pc_i       its PC
// -----------------------------------------------------------------------------
module branch_history_table
  import riscv_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t rd_pc_i,
  output logic  rd_taken_c,
  input  logic  upd_en_i,
  input  logic  upd_taken_i,
  input  word_t upd_pc_i
);

  bht_cnt_e cnt_q [BHT_DEPTH];
  bht_cnt_e cnt_d [BHT_DEPTH];
  bht_idx_t rd_idx_c;
  bht_idx_t upd_idx_c;
  logic     unused_pc_bits_c;

  assign rd_idx_c  = rd_pc_i[WIDTH_ENTRY_LENTH+1:2];
  assign upd_idx_c = upd_pc_i[WIDTH_ENTRY_LENTH+1:2];

  // PC bits outside the index field do not select an entry
  assign unused_pc_bits_c = ^{rd_pc_i[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2],
                              rd_pc_i[1:0],
                              upd_pc_i[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2],
                              upd_pc_i[1:0]};

  // Prediction reads the registered array, so same-cycle updates are not seen
  assign rd_taken_c = cnt_q[rd_idx_c][1];

  // Counter update at the resolved-branch index
  always_comb begin
    cnt_d = cnt_q;
    if (upd_en_i) begin
      cnt_d[upd_idx_c] = cnt_next(cnt_q[upd_idx_c], upd_taken_i);
    end
  end

  // Counter storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
// Instruction-fetch stage: owns the program counter, picks the next PC from
// EX redirect / stall / BTB prediction / sequential, and registers the fetched
// instruction with its PC and prediction into IF/ID.
// Optional feature: define BHT_ENABLE_EN to qualify BTB hits with a table of
// two-bit history counters (branch_history_table). Without it a BTB hit is
// always predicted taken and the branch-resolution inputs are ignored.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   pc_fetch_stage_if.master (control/BTB/memory inputs, PC and IF/ID
//         register outputs)
// -----------------------------------------------------------------------------
module pc_fetch_stage
  import riscv_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pc_fetch_stage_if.master  bus
);

  word_t  pc_q;
  word_t  pc_d;
  word_t  pc_plus4_c;
  word_t  pc_sel_c;
  if_id_t if_id_q;
  if_id_t if_id_d;
  logic   pred_taken_c;

`ifdef BHT_ENABLE_EN
  logic bht_taken_c;

  branch_history_table u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_pc_i     (pc_q),
    .rd_taken_c  (bht_taken_c),
    .upd_en_i    (bus.Br_Resolved),
    .upd_taken_i (bus.Br_Taken),
    .upd_pc_i    (bus.PC_Ex)
  );

  // BTB hit only counts when the history counter leans taken
  assign pred_taken_c = bus.Hit & bht_taken_c;
`else
  logic unused_bht_c;

  // Branch resolution has no consumer without the history table
  assign unused_bht_c = ^{bus.Br_Resolved, bus.Br_Taken, bus.PC_Ex};
  assign pred_taken_c = bus.Hit;
`endif

  // Next-PC select: redirect > stall > predicted target > sequential
  always_comb begin
    pc_plus4_c = pc_q + WIDTH_DATA_LENGTH'(4);
    pc_sel_c   = pc_plus4_c;
    if (bus.Mispredict) begin
      pc_sel_c = bus.Redirect_PC;
    end else if (bus.Stall) begin
      pc_sel_c = pc_q;
    end else if (pred_taken_c) begin
      pc_sel_c = bus.Target_Add;
    end
    // Fetch addresses are always word aligned
    pc_d = pc_sel_c & ~WIDTH_DATA_LENGTH'(3);
  end

  // IF/ID next value: flush > hold > capture
  always_comb begin
    if_id_d = if_id_q;
    if (bus.Mispredict) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (!bus.Stall) begin
      if_id_d.instr       = bus.Instr_In;
      if_id_d.pc          = pc_q;
      if_id_d.pred_taken  = pred_taken_c;
      if_id_d.pred_target = bus.Target_Add;
      if_id_d.valid       = 1'b1;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign bus.PC                = pc_q;
  assign bus.IF_ID_Instr       = if_id_q.instr;
  assign bus.IF_ID_PC          = if_id_q.pc;
  assign bus.IF_ID_Pred_Taken  = if_id_q.pred_taken;
  assign bus.IF_ID_Pred_Target = if_id_q.pred_target;
  assign bus.IF_ID_Valid       = if_id_q.valid;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_stage
// Self-checking bench for pc_fetch_stage. Each driven cycle pushes the
// expected post-edge outputs onto a scoreboard queue; they are popped and
// compared one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_stage;
  import riscv_pipe_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        pt;
    logic [31:0] ptgt;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_pt;
  logic [31:0] m_ptgt;
  logic        m_valid;
  logic [1:0]  m_cnt [8];

  pc_fetch_stage_if ifc ();

  pc_fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Instruction memory: a fixed scramble of the address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign ifc.Instr_In = imem(ifc.PC);

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check_eq("pc",          ifc.PC,                e.pc);
    check_eq("ifid_instr",  ifc.IF_ID_Instr,       e.instr);
    check_eq("ifid_pc",     ifc.IF_ID_PC,          e.ifpc);
    check_eq("ifid_pt",     32'(ifc.IF_ID_Pred_Taken),  32'(e.pt));
    check_eq("ifid_ptgt",   ifc.IF_ID_Pred_Target, e.ptgt);
    check_eq("ifid_valid",  32'(ifc.IF_ID_Valid),  32'(e.valid));
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.ifpc = m_ifpc;
    e.pt = m_pt; e.ptgt = m_ptgt; e.valid = m_valid;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0000_0013; m_ifpc = 32'h0;
    m_pt = 1'b0; m_ptgt = 32'h0; m_valid = 1'b0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 2'b01;
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge
  task automatic step(input logic stall, input logic misp, input logic [31:0] redir,
                      input logic hit, input logic [31:0] tgt,
                      input logic br_res, input logic br_tk, input logic [31:0] pc_ex);
    logic        pt;
    logic [31:0] npc;
    exp_t        e;
    ifc.Stall = stall; ifc.Mispredict = misp; ifc.Redirect_PC = redir;
    ifc.Hit = hit; ifc.Target_Add = tgt;
    ifc.Br_Resolved = br_res; ifc.Br_Taken = br_tk; ifc.PC_Ex = pc_ex;

    pt = hit;
`ifdef BHT_ENABLE_EN
    pt = hit & m_cnt[m_pc[4:2]][1];
`endif
    if (misp)       npc = redir;
    else if (stall) npc = m_pc;
    else if (pt)    npc = tgt;
    else            npc = m_pc + 32'd4;
    npc[1:0] = 2'b00;

    if (misp) begin
      m_instr = 32'h0000_0013; m_ifpc = 32'h0; m_pt = 1'b0; m_ptgt = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = imem(m_pc); m_ifpc = m_pc; m_pt = pt; m_ptgt = tgt; m_valid = 1'b1;
    end
    m_pc = npc;
`ifdef BHT_ENABLE_EN
    if (br_res) begin
      if (br_tk && m_cnt[pc_ex[4:2]] != 2'b11) m_cnt[pc_ex[4:2]] = m_cnt[pc_ex[4:2]] + 2'b01;
      else if (!br_tk && m_cnt[pc_ex[4:2]] != 2'b00) m_cnt[pc_ex[4:2]] = m_cnt[pc_ex[4:2]] - 2'b01;
    end
`endif
    sb_q.push_back(model_snapshot());

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_outputs(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    ifc.Stall = 1'b0; ifc.Mispredict = 1'b0; ifc.Redirect_PC = 32'h0;
    ifc.Hit = 1'b0; ifc.Target_Add = 32'h0;
    ifc.Br_Resolved = 1'b0; ifc.Br_Taken = 1'b0; ifc.PC_Ex = 32'h0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_outputs(model_snapshot());
    check_eq("rst_pc_const", ifc.PC, 32'h0);
    check_eq("rst_nop_const", ifc.IF_ID_Instr, 32'h0000_0013);
    rst = 1'b0;

    // Sequential fetch from reset
    idle();
    check_eq("seq_first_valid", 32'(ifc.IF_ID_Valid), 32'd1);
    idle();
    check_eq("seq_pc8", ifc.PC, 32'h8);

    // BTB hit at PC=8
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
`ifndef BHT_ENABLE_EN
    check_eq("hit_pc", ifc.PC, 32'h40);
    check_eq("hit_pt", 32'(ifc.IF_ID_Pred_Taken), 32'd1);
`endif

    // Stall three cycles at 0x20, then resume
    redirect(32'h1C);
    idle();
    check_eq("stall_start_pc", ifc.PC, 32'h20);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 32'h99C, 1'b0, 1'b0, 32'h0);
    idle();
    check_eq("resume_pc", ifc.PC, 32'h24);
    check_eq("resume_ifpc", ifc.IF_ID_PC, 32'h20);

    // Mispredict overrides stall
    step(1'b1, 1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    check_eq("misp_pc", ifc.PC, 32'h100);
    check_eq("misp_valid", 32'(ifc.IF_ID_Valid), 32'd0);
    check_eq("misp_nop", ifc.IF_ID_Instr, 32'h0000_0013);
    idle();

    // PC wrap and forced alignment
    redirect(32'hFFFF_FFFC);
    idle();
    check_eq("wrap_pc", ifc.PC, 32'h0);
    redirect(32'h203);
    check_eq("align_redir", ifc.PC, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h57, 1'b0, 1'b0, 32'h0);

    // History training at 0x10
    redirect(32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10);
    redirect(32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    check_eq("trained_pc", ifc.PC, 32'h80);
    check_eq("trained_pt", 32'(ifc.IF_ID_Pred_Taken), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      step(($urandom % 4) == 0, ($urandom % 6) == 0, $urandom,
           ($urandom % 3) == 0, $urandom,
           ($urandom % 2) == 0, ($urandom % 2) == 0, 32'($urandom_range(0, 15)) << 2);
    end

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(model_snapshot());
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Counters back to weakly-not-taken after reset
    redirect(32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Instruction-fetch stage of the RISC-V pipeline: owns the program counter, consumes the branch target buffer's hit/target lookup to choose the next PC, and registers fetched instructions into the IF/ID pipeline register. Sits directly upstream of decode and drives the PC that indexes both the branch target buffer and instruction memory. Execute-stage mispredict redirects and hazard-unit stalls are applied here.

## Interface
- WIDTH_DATA_LENGTH, 32, PC/instruction width
- WIDTH_ENTRY_LENTH, 3, history-table index bits, PC[WIDTH_ENTRY_LENTH+1:2]
- RESET_PC, 32'h0, PC value after reset
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Stall  in  1  hold PC and IF/ID
- Mispredict  in  1  EX-stage redirect request
- Redirect_PC  in  32  correct next PC from EX
- Hit  in  1  BTB hit for current PC
- Target_Add  in  32  BTB predicted target for current PC
- Instr_In  in  32  instruction memory read data for current PC (combinational)
- Br_Resolved  in  1  EX resolved a conditional branch this cycle
- Br_Taken  in  1  outcome of that branch
- PC_Ex  in  32  PC of the resolved branch
- PC  out  32  current fetch PC (registered)
- IF_ID_Instr  out  32  registered instruction
- IF_ID_PC  out  32  registered PC of that instruction
- IF_ID_Pred_Taken  out  1  prediction used for it
- IF_ID_Pred_Target  out  32  predicted target carried to EX for mispredict check
- IF_ID_Valid  out  1  IF/ID holds a real instruction

## Operation
- Pred_Taken (combinational) = Hit, qualified by history counter when BHT_EN.
- Next-PC priority: Mispredict → Redirect_PC; else Stall → PC held; else Pred_Taken → Target_Add; else PC+4.
- Bits [1:0] of every next PC forced to 0. PC+4 wraps modulo 2^32 (32'hFFFFFFFC → 32'h0).
- IF/ID update priority: Mispredict → flush (Instr=NOP_INSTR, Valid=0, Pred_Taken=0, Pred_Target=0, PC=0); else Stall → hold all fields; else capture Instr_In, PC, Pred_Taken, Target_Add, Valid=1.
- Mispredict overrides Stall in the same cycle (redirect and flush both occur).
- Reset values: PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PC=0, IF_ID_Pred_Taken=0, IF_ID_Pred_Target=0, IF_ID_Valid=0, all history counters=2'b01.
- Reset asserted mid-operation clears all state immediately, regardless of Stall/Mispredict.

## Timing
- PC to IF/ID latency: 1 cycle. Prediction combinational on PC within the same cycle.
- Mispredict high in cycle n: after edge n, PC=Redirect_PC and IF_ID_Valid=0; redirected instruction in IF/ID after edge n+1.
- Stall high in cycle n: all outputs unchanged after edge n.
- Counter update on edge when Br_Resolved=1; a lookup of the same index in that cycle sees the pre-update value.
- First valid IF/ID entry after reset release: one edge after release, from RESET_PC.

## Configuration
- BHT_ENABLE_EN defined: 2^WIDTH_ENTRY_LENTH two-bit saturating counters indexed by PC; Pred_Taken = Hit & counter[1]. Update at PC_Ex index: Br_Taken increments (saturate at 3), else decrements (saturate at 0).
- Not defined: Pred_Taken = Hit; Br_Resolved, Br_Taken, PC_Ex ignored; no counter storage.

## Structure
- Shared package riscv_pipe_pkg: data width, NOP_INSTR, RESET_PC, counter encodings (SNT=0, WNT=1, WT=2, ST=3).
- One sub-module, branch_history_table (counter array, read port on PC, update port on PC_Ex), instantiated only under BHT_ENABLE_EN.

## Test plan
- Reset release, Hit=0, no stall → PC sequence 0,4,8,12; IF_ID_Valid=1 from the first edge; IF_ID_PC trails PC by one cycle.
- PC=8, Hit=1, Target_Add=0x40 (BHT disabled) → next PC=0x40; IF_ID_Pred_Taken=1, IF_ID_Pred_Target=0x40.
- Stall and Mispredict both high, Redirect_PC=0x100 → PC=0x100, IF_ID_Valid=0, IF_ID_Instr=0x00000013.
- Stall high 3 cycles at PC=0x20 → PC and all IF/ID fields constant; resume continues at 0x24.
- PC=32'hFFFFFFFC, Hit=0 → next PC=0x0.
- BHT_ENABLE_EN: PC=0x10, Hit=1, counter=WNT → not taken; two Br_Resolved/Br_Taken=1 at PC_Ex=0x10 → counter=ST, next lookup predicts taken; rst asserted mid-run → counter back to WNT.
